// File: rtl/tone_gen_pkg.sv
// Shared constants and the ROM-content function for the tone generator.
package tone_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SILENCE = 2'd0,
        MODE_SINE    = 2'd1,
        MODE_SQUARE  = 2'd2,
        MODE_SAW     = 2'd3
    } mode_e;

    // Quarter-wave entry k, sampled at bin centres so the wave is symmetric
    // about each quadrant boundary.
    function automatic int rom_entry(int width, int addr_w, int k);
        real amp;
        real ang;
        amp = real'((1 << (width - 1)) - 1);
        ang = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(1 << addr_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Registered quarter-wave sine ROM, unsigned magnitude of WIDTH-1 bits.
module quarter_sine_rom
    import tone_gen_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LUT_ADDR_W = 6
) (
    input  logic                  clk,
    input  logic [LUT_ADDR_W-1:0] addr,
    output logic [WIDTH-2:0]      data
);

    localparam int DEPTH = 1 << LUT_ADDR_W;
    localparam int DW    = WIDTH - 1;

    logic [DW-1:0] lut [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_lut
        assign lut[k] = DW'(rom_entry(WIDTH, LUT_ADDR_W, k));
    end

    always_ff @(posedge clk) begin
        data <= lut[addr];
    end

endmodule

// File: rtl/tone_gen.sv
// Test-tone source: rate divider, phase accumulator, quarter-wave ROM and
// waveform/attenuation output stage, three cycles from tick to strobe.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 6,
    parameter int RATE_W     = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [RATE_W-1:0]        rate,
    input  logic [PHASE_W-1:0]       phase_step,
    input  logic                     phase_clr,
    input  logic [1:0]               mode,
    input  logic [3:0]               atten,
    output logic signed [WIDTH-1:0]  data_out,
    output logic                     stb_out
);

    localparam int STAGES = 3;
    localparam logic signed [WIDTH-1:0] FULL = {1'b0, {(WIDTH-1){1'b1}}};

    logic [RATE_W-1:0]  cnt;
    logic [RATE_W-1:0]  rate_m1;
    logic               tick;
    logic [STAGES:0]    vld_pipe;

    // rate 0 and 1 both mean a sample every cycle
    assign rate_m1     = (rate == '0) ? '0 : rate - RATE_W'(1);
    assign tick        = enable && (cnt >= rate_m1);
    assign vld_pipe[0] = tick;
    assign stb_out     = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt                  <= '0;
            vld_pipe[STAGES:1]   <= '0;
        end else begin
            cnt                  <= (!enable || tick) ? '0 : cnt + RATE_W'(1);
            vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
        end
    end

    // Stage 1: capture phase and configuration together at tick
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] s1_phase;
    mode_e              s1_mode;
    logic [3:0]         s1_atten;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            s1_phase <= '0;
            s1_mode  <= MODE_SILENCE;
            s1_atten <= '0;
        end else if (tick) begin
            s1_phase <= phase_clr ? '0 : acc;
            acc      <= phase_clr ? phase_step : acc + phase_step;
            s1_mode  <= mode_e'(mode);
            s1_atten <= atten;
        end else if (phase_clr) begin
            acc      <= '0;
        end
    end

    // Stage 2: ROM lookup, odd quadrants walk the table backwards
    logic [1:0]            quad;
    logic [LUT_ADDR_W-1:0] idx;
    logic [LUT_ADDR_W-1:0] rom_addr;
    logic [WIDTH-2:0]      rom_q;

    assign quad     = s1_phase[PHASE_W-1 -: 2];
    assign idx      = s1_phase[PHASE_W-3 -: LUT_ADDR_W];
    assign rom_addr = quad[0] ? ~idx : idx;

    quarter_sine_rom #(
        .WIDTH      (WIDTH),
        .LUT_ADDR_W (LUT_ADDR_W)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_q)
    );

    logic [1:0]               s2_quad;
    mode_e                    s2_mode;
    logic [3:0]               s2_atten;
    logic signed [WIDTH-1:0]  s2_saw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_quad  <= '0;
            s2_mode  <= MODE_SILENCE;
            s2_atten <= '0;
            s2_saw   <= '0;
        end else if (vld_pipe[1]) begin
            s2_quad  <= quad;
            s2_mode  <= s1_mode;
            s2_atten <= s1_atten;
            s2_saw   <= {~s1_phase[PHASE_W-1], s1_phase[PHASE_W-2 -: WIDTH-1]};
        end
    end

    // Stage 3: waveform select and attenuation
    logic signed [WIDTH-1:0] sel;

    always_comb begin
        sel = '0;
        case (s2_mode)
            MODE_SINE:   sel = s2_quad[1] ? -$signed({1'b0, rom_q}) : $signed({1'b0, rom_q});
            MODE_SQUARE: sel = s2_quad[1] ? -FULL : FULL;
            MODE_SAW:    sel = s2_saw;
            default:     sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (vld_pipe[2]) begin
            data_out <= sel >>> s2_atten;
        end
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
Parametrised test-tone source feeding the transmitter's `data_in`/`stb_in` path. It replaces the fixed 20-entry sine table and the external strober with four elements:
- an internal sample-rate divider;
- a programmable phase accumulator;
- a quarter-wave sine ROM;
- selectable waveform mode with attenuation.

It produces signed samples with a one-cycle strobe at a runtime-programmable rate and frequency.

Parameters:
- WIDTH, 16, sample width (signed two's complement).
- PHASE_W, 24, phase accumulator width; must be >= WIDTH and >= LUT_ADDR_W+2.
- LUT_ADDR_W, 6, quarter-wave ROM address width (2^LUT_ADDR_W entries).
- RATE_W, 12, width of the sample-rate divider.

Ports:
- clk  in  1  system clock (clk_216 domain).
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  high: divider runs and samples are produced.
- rate  in  RATE_W  clocks per sample period.
- phase_step  in  PHASE_W  phase increment per sample; tone freq = fs*phase_step/2^PHASE_W.
- phase_clr  in  1  synchronous clear of the accumulator.
- mode  in  2  waveform select: 0 silence, 1 sine, 2 square, 3 sawtooth.
- atten  in  4  arithmetic right-shift applied to the output.
- data_out  out  WIDTH  signed sample.
- stb_out  out  1  one-cycle valid pulse for data_out.

Behaviour:
- Reset (rst_n low, async):
  - Divider counter, phase accumulator and all pipeline registers clear to 0.
  - data_out=0, stb_out=0.
  - Reset mid-operation discards in-flight samples; no stb_out is produced for them.
- Divider:
  - While enable=1, the counter increments each clk.
  - tick = enable && (counter >= rate-1); on tick the counter returns to 0. The >= comparison makes a rate reduced below the current count wrap immediately.
  - rate 0 or 1: tick every cycle.
  - enable=0: counter is held at 0 and no ticks occur. Samples already in the pipeline still complete.
- Stage 1 (on tick):
  - Register phase_acc (value before increment) together with mode and atten.
  - phase_acc <= phase_acc + phase_step, mod 2^PHASE_W.
  - phase_clr without tick: phase_acc <= 0.
  - phase_clr with tick: the sample uses phase 0 and phase_acc <= phase_step.
- Stage 2: registered ROM read.
  - Quadrant q = phase[PHASE_W-1:PHASE_W-2].
  - Index i = next LUT_ADDR_W bits.
  - Address = i for q even, ~i for q odd.
  - q, mode, atten and the saw value are carried alongside.
- ROM content: entry k = round((2^(WIDTH-1)-1) * sin(pi/2 * (k+0.5) / 2^LUT_ADDR_W)), unsigned, WIDTH-1 bits.
- Stage 3: output register.
  - sine: q<2 gives +rom, otherwise -rom.
  - square: q<2 gives +(2^(WIDTH-1)-1), otherwise -(2^(WIDTH-1)-1).
  - saw: phase[PHASE_W-1 -: WIDTH] with MSB inverted, spanning -2^(WIDTH-1)..2^(WIDTH-1)-1.
  - silence: 0.
  - The selected value is then arithmetic-shifted right by atten.
- Latency: stb_out is high exactly 3 cycles after the tick cycle, with data_out valid in that same cycle.
- data_out holds its value between strobes.
- Configuration is sampled only at tick, so changes to step, mode or atten never produce a mixed sample.
- Maximum throughput: one sample per cycle (rate<=1). The pipeline is fully streaming, with no stalls.

Decomposition:
- tone_gen_pkg holds:
  - mode constants MODE_SILENCE, MODE_SINE, MODE_SQUARE, MODE_SAW;
  - a constant function computing ROM entry k for given WIDTH and LUT_ADDR_W.
- One sub-module, quarter_sine_rom:
  - parameters WIDTH, LUT_ADDR_W;
  - ports clk, addr, registered data out;
  - contents generated from the package function;
  - no reset needed.

Test Plan:
All cases use WIDTH=16, PHASE_W=24, LUT_ADDR_W=6.
1. Reset/enable: hold rst_n=0 and check data_out=0, stb_out=0. Then release with enable=1, rate=4 -> first stb_out 3 cycles after the first tick (cycle 4 after enable), thereafter exactly every 4 cycles. Deassert enable -> at most 3 further strobes, then none.
2. Sine ROM corners: mode=1, atten=0, phase_step=2^16 (one ROM step per sample) -> first samples 402, 1206, ...; sample 63 = 32765, sample 64 = 32765, sample 127 = 402, sample 128 = -402. Period is 256 samples.
3. Square/saw/silence: phase_step=2^22 -> square gives +32767 ×2 then -32767 ×2. Saw gives -32768, -16384, 0, 16384. Mode 0 gives all 0s with stb_out still pulsing.
4. Attenuation and config timing: sine at the peak with atten=3 -> 4095 (32765>>>3); negative peak -> -4096. Change mode and atten between ticks -> the change applies from the next sample only.
5. Phase clear: assert phase_clr coincident with a tick -> that sample is sine(0)=402, and the next sample uses phase=phase_step. Assert phase_clr away from a tick -> the next sample is 402.
6. Boundaries: rate=1 -> stb_out every cycle. Reduce rate from 100 to 5 while the counter is at 50 -> tick on the next cycle. Assert rst_n=0 mid-stream -> the output is 0 immediately and no stale stb_out appears after release.
